// File: rtl/puvvada_pattern_sequencer_if.sv
// ---------------------------------------------------------------------------
// puvvada_pattern_sequencer_if
//
// Groups every signal between the Simon pattern sequencer and its
// surroundings except the clock and reset.
//
//   Tick            pacing strobe, one Clk wide
//   Clear           empty the pattern and return to IDLE
//   Append          add one pseudo-random colour (IDLE only)
//   Start           play the pattern, then accept presses (IDLE only)
//   Btn[3:0]        button press pulses {L,D,R,U}
//   Color[3:0]      one-hot LED drive, same mapping as Btn
//   Len             current pattern length
//   Full            Len has reached the pattern memory depth
//   q_Idle/q_Show/q_Gap/q_Wait   state flags, exactly one is high
//   Pass/Fail       one-Clk result pulses
//
// Handshake semantics: there is no valid/ready pairing on this bus. Every
// request (Clear, Append, Start, Btn) is a strobe that is acted on in the
// single Clk cycle it is high and is never held or queued; a strobe arriving
// in a state that does not accept it is dropped. Pass and Fail are strobes
// from the sequencer that are high for exactly one Clk cycle, in the cycle
// the state flags first show IDLE.
//
// Modports: master = game state machine / board side, slave = sequencer.
// ---------------------------------------------------------------------------
interface puvvada_pattern_sequencer_if #(
    parameter int LEN_W = 6
) ();
    logic             Tick;
    logic             Clear;
    logic             Append;
    logic             Start;
    logic [3:0]       Btn;
    logic [3:0]       Color;
    logic [LEN_W-1:0] Len;
    logic             Full;
    logic             q_Idle;
    logic             q_Show;
    logic             q_Gap;
    logic             q_Wait;
    logic             Pass;
    logic             Fail;

    modport master (
        output Tick, Clear, Append, Start, Btn,
        input  Color, Len, Full, q_Idle, q_Show, q_Gap, q_Wait, Pass, Fail
    );

    modport slave (
        input  Tick, Clear, Append, Start, Btn,
        output Color, Len, Full, q_Idle, q_Show, q_Gap, q_Wait, Pass, Fail
    );
endinterface

// File: rtl/puvvada_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// puvvada_pattern_sequencer
//
// Owns the Simon colour pattern: stores it, appends one pseudo-random colour
// per Append, plays it on the colour LEDs paced by Tick, then checks the
// player's presses against it and reports Pass or Fail.
//
// Ports:
//   Clk      system clock, all state changes on the rising edge
//   Reset_n  asynchronous active-low reset
//   bus      puvvada_pattern_sequencer_if.slave (Tick, Clear, Append, Start,
//            Btn in; Color, Len, Full, q_* state flags, Pass, Fail out)
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   - in WAIT, TIMEOUT_TICKS Tick strobes without a press -> Fail
//   undefined - WAIT waits for a press indefinitely
// ---------------------------------------------------------------------------
module puvvada_pattern_sequencer #(
    parameter int MAX_LEVEL     = 32,
    parameter int LEN_W         = 6,
    parameter int ON_TICKS      = 4,
    parameter int OFF_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 16
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    puvvada_pattern_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam int ADDR_W  = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
    localparam int CNT_MAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CNT_MAX = (CNT_MAX0 > TIMEOUT_TICKS) ? CNT_MAX0 : TIMEOUT_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       color_q, color_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [7:0]       lfsr_q;
    logic             mem_we;

    logic [1:0]       mem [MAX_LEVEL];
    logic [1:0]       cur_code;
    logic [1:0]       next_code;
    logic             full;
    logic             last_idx;
    logic             btn_any;
    logic             btn_onehot;

    function automatic logic [3:0] code_to_led(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

    assign full       = (len_q == LEN_W'(MAX_LEVEL));
    assign last_idx   = (idx_q == len_q - LEN_W'(1));
    assign cur_code   = mem[idx_q[ADDR_W-1:0]];
    assign next_code  = mem[idx_q[ADDR_W-1:0] + ADDR_W'(1)];
    assign btn_any    = (bus.Btn != 4'd0);
    assign btn_onehot = btn_any && ((bus.Btn & (bus.Btn - 4'd1)) == 4'd0);

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        mem_we  = 1'b0;

        if (bus.Clear) begin
            state_d = S_IDLE;
            len_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
            color_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // An Append strobe claims the cycle even when the memory
                    // is full, so a simultaneous Start is always dropped.
                    if (bus.Append) begin
                        if (!full) begin
                            mem_we = 1'b1;
                            len_d  = len_q + LEN_W'(1);
                        end
                    end else if (bus.Start && (len_q != '0)) begin
                        state_d = S_SHOW;
                        idx_d   = '0;
                        cnt_d   = '0;
                        color_d = code_to_led(mem[0]);
                    end
                end

                S_SHOW: begin
                    if (bus.Tick) begin
                        if (cnt_q == CNT_W'(ON_TICKS - 1)) begin
                            state_d = S_GAP;
                            cnt_d   = '0;
                            color_d = 4'd0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end

                S_GAP: begin
                    if (bus.Tick) begin
                        if (cnt_q == CNT_W'(OFF_TICKS - 1)) begin
                            cnt_d = '0;
                            if (last_idx) begin
                                state_d = S_WAIT;
                                idx_d   = '0;
                            end else begin
                                state_d = S_SHOW;
                                idx_d   = idx_q + LEN_W'(1);
                                color_d = code_to_led(next_code);
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end

                S_WAIT: begin
                    if (btn_any) begin
                        cnt_d = '0;
                        if (!btn_onehot || (bus.Btn != code_to_led(cur_code))) begin
                            fail_d  = 1'b1;
                            state_d = S_IDLE;
                            idx_d   = '0;
                        end else if (last_idx) begin
                            pass_d  = 1'b1;
                            state_d = S_IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + LEN_W'(1);
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (bus.Tick) begin
                        // A press (handled above) restarts the count.
                        if (cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
                            fail_d  = 1'b1;
                            state_d = S_IDLE;
                            idx_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
`endif
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            color_q <= 4'd0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            lfsr_q  <= 8'hA5;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running in every state.
            lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // Pattern memory has no reset; only entries below len are ever read.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[len_q[ADDR_W-1:0]] <= lfsr_q[1:0];
        end
    end

    assign bus.Color  = color_q;
    assign bus.Len    = len_q;
    assign bus.Full   = full;
    assign bus.q_Idle = (state_q == S_IDLE);
    assign bus.q_Show = (state_q == S_SHOW);
    assign bus.q_Gap  = (state_q == S_GAP);
    assign bus.q_Wait = (state_q == S_WAIT);
    assign bus.Pass   = pass_q;
    assign bus.Fail   = fail_q;

endmodule

// File: tb/tb_puvvada_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_puvvada_pattern_sequencer
//
// Directed bench for puvvada_pattern_sequencer. Stimulus drives inputs on the
// falling clock edge and pushes expected responses into three queues:
//   exp_obs_q  {ticks spent in previous segment (FF = any), state flags+Color}
//   exp_len_q  {Full, Len}
//   exp_res_q  {Pass, Fail}
// A monitor on the falling edge pops and compares whenever the matching DUT
// output changes (or a Pass/Fail pulse is present).
// Build with +define+SEQ_TIMEOUT_EN to add the timeout scenarios.
// ---------------------------------------------------------------------------
module tb_puvvada_pattern_sequencer;

    localparam int MAX_LEVEL = 32;
    localparam int LEN_W     = 6;

    localparam logic [7:0] OBS_IDLE = 8'h80;
    localparam logic [7:0] OBS_GAP  = 8'h20;
    localparam logic [7:0] OBS_WAIT = 8'h10;
    localparam logic [7:0] ANY_T    = 8'hFF;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    puvvada_pattern_sequencer_if #(.LEN_W(LEN_W)) bus ();

    puvvada_pattern_sequencer #(
        .MAX_LEVEL    (MAX_LEVEL),
        .LEN_W        (LEN_W),
        .ON_TICKS     (4),
        .OFF_TICKS    (2),
        .TIMEOUT_TICKS(16)
    ) dut (
        .Clk    (clk),
        .Reset_n(rst_n),
        .bus    (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [15:0]      exp_obs_q[$];
    logic [LEN_W:0]   exp_len_q[$];
    logic [1:0]       exp_res_q[$];
    int               n_vec  = 0;
    int               n_miss = 0;

    // Reference colour source and pattern model.
    logic [7:0] m_lfsr;
    logic [1:0] m_mem [MAX_LEVEL];
    int         m_len   = 0;
    int         tick_ph = 0;
    int         tick_total = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    always @(posedge clk) begin
        if (bus.Tick) tick_total <= tick_total + 1;
    end

    function automatic logic [3:0] led(input logic [1:0] c);
        case (c)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [7:0] obs_show(input logic [1:0] c);
        return {4'b0100, led(c)};
    endfunction

    function automatic bit next_is_tick();
        return ((tick_ph + 1) % 4) == 0;
    endfunction

    // ---------------- driver tasks ----------------
    // Applies one cycle of inputs (call right after a falling edge) and keeps
    // the pattern model in step with Append/Clear.
    task automatic drive(input logic app, input logic st, input logic clr, input logic [3:0] btn);
        tick_ph    = (tick_ph + 1) % 4;
        bus.Tick   = (tick_ph == 0);
        bus.Append = app;
        bus.Start  = st;
        bus.Clear  = clr;
        bus.Btn    = btn;
        if (clr) begin
            if (m_len != 0) exp_len_q.push_back('0);
            m_len = 0;
        end else if (app && m_len < MAX_LEVEL) begin
            m_mem[m_len] = m_lfsr[1:0];
            m_len++;
            exp_len_q.push_back({(m_len == MAX_LEVEL), LEN_W'(m_len)});
        end
    endtask

    task automatic step(input logic app, input logic st, input logic clr, input logic [3:0] btn);
        @(negedge clk);
        drive(app, st, clr, btn);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Append exactly when the colour about to be sampled is 'want'.
    task automatic append_color(input logic [1:0] want);
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (m_lfsr[1:0] == want) begin
                drive(1'b1, 1'b0, 1'b0, 4'd0);
                done = 1;
            end else begin
                drive(1'b0, 1'b0, 1'b0, 4'd0);
            end
        end
        if (!done) begin
            n_vec++; n_miss++;
            $display("FAIL append_color: colour %0d never offered, required within 400 cycles", want);
        end
        idle(1);
    endtask

    task automatic push_playback();
        for (int i = 0; i < m_len; i++) begin
            exp_obs_q.push_back({(i == 0) ? ANY_T : 8'd2, obs_show(m_mem[i])});
            exp_obs_q.push_back({8'd4, OBS_GAP});
        end
        exp_obs_q.push_back({8'd2, OBS_WAIT});
    endtask

    task automatic wait_wait(input bit show_btn);
        int n = 0;
        while (!bus.q_Wait && n < 1000) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0,
                  (show_btn && bus.q_Show) ? ((n % 2 == 0) ? 4'b0101 : 4'b0001) : 4'b0000);
            n++;
        end
        if (!bus.q_Wait) begin
            n_vec++; n_miss++;
            $display("FAIL reach_wait: q_Wait=%b after %0d cycles, required 1", bus.q_Wait, n);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.q_Idle && n < 400) begin
            step(1'b0, 1'b0, 1'b0, 4'd0);
            n++;
        end
        if (!bus.q_Idle) begin
            n_vec++; n_miss++;
            $display("FAIL reach_idle: q_Idle=%b after %0d cycles, required 1", bus.q_Idle, n);
        end
    endtask

    task automatic start_play(input bit show_btn);
        push_playback();
        step(1'b0, 1'b1, 1'b0, 4'd0);
        wait_wait(show_btn);
    endtask

    task automatic press(input logic [3:0] btn);
        step(1'b0, 1'b0, 1'b0, btn);
        step(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic answer_correct();
        for (int i = 0; i < m_len; i++) begin
            if (i == m_len - 1) begin
                exp_res_q.push_back(2'b10);
                exp_obs_q.push_back({ANY_T, OBS_IDLE});
            end
            press(led(m_mem[i]));
        end
    endtask

    task automatic expect_fail();
        exp_res_q.push_back(2'b01);
        exp_obs_q.push_back({ANY_T, OBS_IDLE});
    endtask

    // ---------------- monitor ----------------
    logic [7:0]     last_obs = 8'h00;
    logic [LEN_W:0] last_lf  = '1;
    int             last_tick = 0;
    logic [7:0]     mon_obs;
    logic [LEN_W:0] mon_lf;
    logic [15:0]    mon_e;
    logic [LEN_W:0] mon_el;
    logic [1:0]     mon_er;
    int             mon_seg;

    always @(negedge clk) begin
        mon_obs = {bus.q_Idle, bus.q_Show, bus.q_Gap, bus.q_Wait, bus.Color};
        if (mon_obs !== last_obs) begin
            mon_seg = tick_total - last_tick;
            n_vec++;
            if (exp_obs_q.size() == 0) begin
                n_miss++;
                $display("FAIL obs: unexpected change to flags/color %h after %0d ticks, required no change",
                         mon_obs, mon_seg);
            end else begin
                mon_e = exp_obs_q.pop_front();
                if (mon_e[7:0] !== mon_obs || (mon_e[15:8] != ANY_T && mon_e[15:8] != mon_seg[7:0])) begin
                    n_miss++;
                    $display("FAIL obs: got flags/color %h after %0d ticks, required %h after %0d ticks (255=any)",
                             mon_obs, mon_seg, mon_e[7:0], mon_e[15:8]);
                end
            end
            last_obs  = mon_obs;
            last_tick = tick_total;
        end

        mon_lf = {bus.Full, bus.Len};
        if (mon_lf !== last_lf) begin
            n_vec++;
            if (exp_len_q.size() == 0) begin
                n_miss++;
                $display("FAIL len: unexpected change to Full=%b Len=%0d, required no change", bus.Full, bus.Len);
            end else begin
                mon_el = exp_len_q.pop_front();
                if (mon_el !== mon_lf) begin
                    n_miss++;
                    $display("FAIL len: got Full=%b Len=%0d, required Full=%b Len=%0d",
                             mon_lf[LEN_W], mon_lf[LEN_W-1:0], mon_el[LEN_W], mon_el[LEN_W-1:0]);
                end
            end
            last_lf = mon_lf;
        end

        if (bus.Pass !== 1'b0 || bus.Fail !== 1'b0) begin
            n_vec++;
            if (exp_res_q.size() == 0) begin
                n_miss++;
                $display("FAIL result: unexpected Pass=%b Fail=%b, required none", bus.Pass, bus.Fail);
            end else begin
                mon_er = exp_res_q.pop_front();
                if (mon_er !== {bus.Pass, bus.Fail}) begin
                    n_miss++;
                    $display("FAIL result: got Pass=%b Fail=%b, required Pass=%b Fail=%b",
                             bus.Pass, bus.Fail, mon_er[1], mon_er[0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bus.Tick   = 1'b0;
        bus.Clear  = 1'b0;
        bus.Append = 1'b0;
        bus.Start  = 1'b0;
        bus.Btn    = 4'd0;

        // Reset state: IDLE, Color=0, Len=0, Full=0.
        exp_obs_q.push_back({ANY_T, OBS_IDLE});
        exp_len_q.push_back('0);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Three appends at uneven spacing; contents checked through playback.
        step(1'b1, 1'b0, 1'b0, 4'd0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        idle(5);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        idle(2);
        start_play(1'b0);
        answer_correct();
        idle(3);

        // Pattern {R,L}: R lit 4 ticks, dark 2, L lit 4, dark 2, then WAIT.
        step(1'b0, 1'b0, 1'b1, 4'd0);
        idle(2);
        append_color(2'd1);
        append_color(2'd3);
        start_play(1'b0);
        press(4'b0010);
        exp_res_q.push_back(2'b10);
        exp_obs_q.push_back({ANY_T, OBS_IDLE});
        press(4'b1000);
        idle(3);

        // Correct first press, wrong second press.
        start_play(1'b0);
        press(4'b0010);
        expect_fail();
        press(4'b0001);
        idle(3);

        // Two buttons at once.
        start_play(1'b0);
        expect_fail();
        press(4'b0011);
        idle(3);

        // Presses during playback are ignored.
        start_play(1'b1);
        answer_correct();
        idle(3);

        // Append and Start together: only the Append takes effect.
        step(1'b1, 1'b1, 1'b0, 4'd0);
        idle(8);
        step(1'b0, 1'b0, 1'b1, 4'd0);
        idle(2);
        // Start on an empty pattern stays in IDLE.
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle(10);

        // Fill to the top, then one more Append that must be ignored.
        repeat (MAX_LEVEL + 1) step(1'b1, 1'b0, 1'b0, 4'd0);
        idle(2);
        // Clear in the middle of the first colour.
        exp_obs_q.push_back({ANY_T, obs_show(m_mem[0])});
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle(3);
        exp_obs_q.push_back({ANY_T, OBS_IDLE});
        step(1'b0, 1'b0, 1'b1, 4'd0);
        idle(3);

        // Asynchronous reset while waiting for input: no pulse, reset values.
        append_color(2'd2);
        start_play(1'b0);
        exp_obs_q.push_back({ANY_T, OBS_IDLE});
        exp_len_q.push_back('0);
        m_len = 0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #6 rst_n = 1'b1;
        idle(4);

`ifdef SEQ_TIMEOUT_EN
        append_color(2'd1);
        append_color(2'd3);

        // No press: Fail on the 16th Tick in WAIT.
        start_play(1'b0);
        exp_res_q.push_back(2'b01);
        exp_obs_q.push_back({8'd16, OBS_IDLE});
        wait_idle();
        idle(3);

        // Correct press on the 15th Tick restarts the count: 15 + 16 ticks.
        begin
            int wt;
            start_play(1'b0);
            wt = bus.Tick ? 1 : 0;
            while (wt < 14) begin
                step(1'b0, 1'b0, 1'b0, 4'd0);
                if (bus.Tick) wt++;
            end
            while (!next_is_tick()) step(1'b0, 1'b0, 1'b0, 4'd0);
            exp_res_q.push_back(2'b01);
            exp_obs_q.push_back({8'd31, OBS_IDLE});
            step(1'b0, 1'b0, 1'b0, led(m_mem[0]));
            wait_idle();
            idle(3);
        end
`endif

        idle(10);

        // Anything still expected but never observed is a miscompare.
        while (exp_obs_q.size() > 0) begin
            mon_e = exp_obs_q.pop_front();
            n_vec++; n_miss++;
            $display("FAIL obs_pending: never saw flags/color %h, required it", mon_e[7:0]);
        end
        while (exp_len_q.size() > 0) begin
            mon_el = exp_len_q.pop_front();
            n_vec++; n_miss++;
            $display("FAIL len_pending: never saw Full=%b Len=%0d, required it", mon_el[LEN_W], mon_el[LEN_W-1:0]);
        end
        while (exp_res_q.size() > 0) begin
            mon_er = exp_res_q.pop_front();
            n_vec++; n_miss++;
            $display("FAIL result_pending: never saw Pass=%b Fail=%b, required it", mon_er[1], mon_er[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
